// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: forwarding-select codes and hazard sequencer state encodings shared by the pipeline.
package mips_pipe_pkg;
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;
    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_DIV_WAIT = 2'b01,
        HZ_FLUSH    = 2'b10
    } hz_state_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand register match against EX/MEM/WB producers and ID branch-compare forward select.
module hazard_fwd_sel
    import mips_pipe_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          use_r,
    input  logic [AW-1:0] r,
    input  logic [AW-1:0] id_ex_rd,
    input  logic [AW-1:0] ex_mem_rd,
    input  logic [AW-1:0] mem_wb_rd,
    input  logic          ex_mem_regwrite,
    input  logic          ex_mem_mem2reg,
    input  logic          mem_wb_regwrite,
    output logic          hit_ex,
    output logic          hit_mem,
    output logic [1:0]    fwd
);
    logic hit_wb;
    // $0 is hard-wired, so a zero operand never matches anything
    assign hit_ex  = use_r && (|r) && r == id_ex_rd;
    assign hit_mem = use_r && (|r) && r == ex_mem_rd;
    assign hit_wb  = use_r && (|r) && r == mem_wb_rd;
    assign fwd = (ex_mem_regwrite && !ex_mem_mem2reg && hit_mem) ? FWD_EXMEM :
                 (mem_wb_regwrite && hit_wb) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencer for the 5-stage pipeline, including multi-cycle divider wait.
// Optional HAZ_PERF_CNT_EN adds stall_cycles, div_cycles and flush_count performance counters.
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int AW          = 5,
    parameter int DIV_TIMEOUT = 40
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ID_Rs,
    input  logic [AW-1:0] ID_Rt,
    input  logic          ID_use_rs,
    input  logic          ID_use_rt,
    input  logic          ID_Beq,
    input  logic [AW-1:0] ID_EX_Rd,
    input  logic          ID_EX_RegWrite,
    input  logic          ID_EX_Mem2Reg,
    input  logic          ID_EX_div,
    input  logic [AW-1:0] EX_MEM_Rd,
    input  logic          EX_MEM_RegWrite,
    input  logic          EX_MEM_Mem2Reg,
    input  logic [AW-1:0] MEM_WB_Rd,
    input  logic          MEM_WB_RegWrite,
    input  logic          MEM_exc,
    input  logic          div_done,
    output logic          stall,
    output logic          stall_EX,
    output logic          flush,
    output logic [3:0]    forwardSignal,
    output logic          div_start,
    output logic          div_abort
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] div_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    localparam int CW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    hz_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [1:0] fwd_rs, fwd_rt;
    logic ex_rs, ex_rt, mem_rs, mem_rt, haz, timeout;

    hazard_fwd_sel #(.AW(AW)) u_rs (
        .use_r(ID_use_rs), .r(ID_Rs), .id_ex_rd(ID_EX_Rd), .ex_mem_rd(EX_MEM_Rd), .mem_wb_rd(MEM_WB_Rd),
        .ex_mem_regwrite(EX_MEM_RegWrite), .ex_mem_mem2reg(EX_MEM_Mem2Reg), .mem_wb_regwrite(MEM_WB_RegWrite),
        .hit_ex(ex_rs), .hit_mem(mem_rs), .fwd(fwd_rs)
    );
    hazard_fwd_sel #(.AW(AW)) u_rt (
        .use_r(ID_use_rt), .r(ID_Rt), .id_ex_rd(ID_EX_Rd), .ex_mem_rd(EX_MEM_Rd), .mem_wb_rd(MEM_WB_Rd),
        .ex_mem_regwrite(EX_MEM_RegWrite), .ex_mem_mem2reg(EX_MEM_Mem2Reg), .mem_wb_regwrite(MEM_WB_RegWrite),
        .hit_ex(ex_rt), .hit_mem(mem_rt), .fwd(fwd_rt)
    );

    // ID-stage branches cannot take an operand still in EX, nor a load result still in MEM
    assign haz = (ID_EX_Mem2Reg && ID_EX_RegWrite && (ex_rs || ex_rt)) ||
                 (ID_Beq && ((ID_EX_RegWrite && (ex_rs || ex_rt)) || (EX_MEM_Mem2Reg && (mem_rs || mem_rt))));
    assign timeout = cnt == CW'(DIV_TIMEOUT - 1);

    always_comb begin
        nxt = state;
        stall = 1'b0;
        stall_EX = 1'b0;
        flush = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        if (MEM_exc) begin
            flush = 1'b1;
            div_abort = state == HZ_DIV_WAIT;
            nxt = HZ_FLUSH;
        end else begin
            case (state)
                HZ_RUN: begin
                    stall = haz;
                    div_start = ID_EX_div;
                    nxt = ID_EX_div ? HZ_DIV_WAIT : HZ_RUN;
                end
                HZ_DIV_WAIT: begin
                    stall = !div_done;
                    stall_EX = !div_done;
                    div_abort = !div_done && timeout;
                    nxt = div_done ? HZ_RUN : timeout ? HZ_FLUSH : HZ_DIV_WAIT;
                end
                HZ_FLUSH: begin
                    flush = 1'b1;
                    nxt = HZ_RUN;
                end
                default: nxt = HZ_RUN;
            endcase
        end
        forwardSignal = (stall || rst) ? {FWD_REG, FWD_REG} : {fwd_rs, fwd_rt};
        if (rst) begin
            stall = 1'b0;
            stall_EX = 1'b0;
            flush = 1'b0;
            div_start = 1'b0;
            div_abort = 1'b0;
        end
    end

    // counter is held at zero outside DIV_WAIT, so each divide starts its count fresh
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_RUN;
            cnt <= '0;
        end else begin
            state <= nxt;
            cnt <= (state != HZ_DIV_WAIT) ? '0 : timeout ? cnt : cnt + 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            div_cycles <= '0;
            flush_count <= '0;
        end else begin
            stall_cycles <= stall_cycles + CNT_W'(stall);
            div_cycles <= div_cycles + CNT_W'(state == HZ_DIV_WAIT);
            flush_count <= flush_count + CNT_W'(nxt == HZ_FLUSH);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (default build).
module tb_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] ID_Rs, ID_Rt, ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd;
    logic ID_use_rs, ID_use_rt, ID_Beq, ID_EX_RegWrite, ID_EX_Mem2Reg, ID_EX_div;
    logic EX_MEM_RegWrite, EX_MEM_Mem2Reg, MEM_WB_RegWrite, MEM_exc, div_done;
    logic stall, stall_EX, flush, div_start, div_abort;
    logic [3:0] forwardSignal;
    int n_cmp = 0, n_err = 0;

    hazard_ctrl #(.AW(5), .DIV_TIMEOUT(40)) dut (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_Beq(ID_Beq), .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Mem2Reg(ID_EX_Mem2Reg),
        .ID_EX_div(ID_EX_div), .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_Mem2Reg(EX_MEM_Mem2Reg), .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_exc(MEM_exc), .div_done(div_done), .stall(stall), .stall_EX(stall_EX), .flush(flush),
        .forwardSignal(forwardSignal), .div_start(div_start), .div_abort(div_abort)
    );

    always #5 clk = ~clk;

    // packed view: {stall, stall_EX, flush, div_start, div_abort, forwardSignal}
    function automatic logic [8:0] obs();
        return {stall, stall_EX, flush, div_start, div_abort, forwardSignal};
    endfunction

    task automatic clr();
        {ID_Rs, ID_Rt, ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd} = '0;
        {ID_use_rs, ID_use_rt, ID_Beq, ID_EX_RegWrite, ID_EX_Mem2Reg, ID_EX_div} = '0;
        {EX_MEM_RegWrite, EX_MEM_Mem2Reg, MEM_WB_RegWrite, MEM_exc, div_done} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ID_Rs = 5'd2; ID_use_rs = 1'b1; ID_EX_Rd = 5'd2; ID_EX_RegWrite = 1'b1; ID_EX_Mem2Reg = 1'b1;
        MEM_exc = 1'b1; MEM_WB_Rd = 5'd2; MEM_WB_RegWrite = 1'b1;
        step(); #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 9'b0); end
        clr(); step(); rst = 1'b0; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL reset_idle got=%b exp=%b", obs(), 9'b0); end
        step();
    endtask

    task automatic test_load_use();
        clr(); ID_Rt = 5'd2; ID_use_rt = 1'b1; ID_EX_Rd = 5'd2; ID_EX_RegWrite = 1'b1; ID_EX_Mem2Reg = 1'b1;
        MEM_WB_Rd = 5'd2; MEM_WB_RegWrite = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b10000_0000) begin n_err++; $display("FAIL load_use got=%b exp=%b", obs(), 9'b10000_0000); end
        step(); clr(); ID_Rt = 5'd2; ID_use_rt = 1'b1; EX_MEM_Rd = 5'd2; EX_MEM_RegWrite = 1'b1; EX_MEM_Mem2Reg = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL load_use_after got=%b exp=%b", obs(), 9'b0); end
        step(); clr(); ID_Rs = 5'd0; ID_use_rs = 1'b1; ID_EX_Rd = 5'd0; ID_EX_RegWrite = 1'b1; ID_EX_Mem2Reg = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL load_use_r0 got=%b exp=%b", obs(), 9'b0); end
        step();
    endtask

    task automatic test_forward();
        clr(); ID_Beq = 1'b1; ID_Rs = 5'd3; ID_Rt = 5'd4; ID_use_rs = 1'b1; ID_use_rt = 1'b1;
        EX_MEM_Rd = 5'd3; EX_MEM_RegWrite = 1'b1; MEM_WB_Rd = 5'd4; MEM_WB_RegWrite = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b00000_0110) begin n_err++; $display("FAIL fwd_beq got=%b exp=%b", obs(), 9'b00000_0110); end
        step(); ID_Rs = 5'd0; ID_Rt = 5'd0; EX_MEM_Rd = 5'd0; MEM_WB_Rd = 5'd0; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL fwd_r0 got=%b exp=%b", obs(), 9'b0); end
        step(); ID_Rs = 5'd5; ID_Rt = 5'd6; EX_MEM_Rd = 5'd5; MEM_WB_Rd = 5'd5; #2;
        n_cmp++; if (obs() !== 9'b00000_0100) begin n_err++; $display("FAIL fwd_priority got=%b exp=%b", obs(), 9'b00000_0100); end
        step(); ID_Rt = 5'd5; ID_use_rs = 1'b0; #2;
        n_cmp++; if (obs() !== 9'b00000_0001) begin n_err++; $display("FAIL fwd_use_rs_off got=%b exp=%b", obs(), 9'b00000_0001); end
        step(); EX_MEM_Mem2Reg = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b10000_0000) begin n_err++; $display("FAIL beq_load_mem got=%b exp=%b", obs(), 9'b10000_0000); end
        step(); clr(); ID_Beq = 1'b1; ID_Rs = 5'd7; ID_use_rs = 1'b1; ID_EX_Rd = 5'd7; ID_EX_RegWrite = 1'b1;
        MEM_WB_Rd = 5'd7; MEM_WB_RegWrite = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b10000_0000) begin n_err++; $display("FAIL beq_alu_ex got=%b exp=%b", obs(), 9'b10000_0000); end
        step(); ID_Beq = 1'b0; #2;
        n_cmp++; if (obs() !== 9'b00000_1000) begin n_err++; $display("FAIL alu_ex_nostall got=%b exp=%b", obs(), 9'b00000_1000); end
        step();
    endtask

    task automatic test_div();
        int bad = 0;
        clr(); ID_EX_div = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b00010_0000) begin n_err++; $display("FAIL div_start got=%b exp=%b", obs(), 9'b00010_0000); end
        step(); ID_EX_div = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            #2; if (obs() !== 9'b11000_0000) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL div_wait_stall bad_cycles=%0d exp=0", bad); end
        div_done = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL div_done got=%b exp=%b", obs(), 9'b0); end
        step(); div_done = 1'b0; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL div_back_run got=%b exp=%b", obs(), 9'b0); end
        step(); div_done = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL done_in_run got=%b exp=%b", obs(), 9'b0); end
        step(); div_done = 1'b0;
    endtask

    task automatic test_timeout();
        int bad = 0;
        clr(); ID_EX_div = 1'b1; step(); ID_EX_div = 1'b0;
        for (int i = 1; i <= 39; i++) begin
            #2; if (obs() !== 9'b11000_0000) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL timeout_wait bad_cycles=%0d exp=0", bad); end
        #2;
        n_cmp++; if ({flush, div_abort, div_start} !== 3'b010) begin n_err++; $display("FAIL timeout_abort got=%b exp=%b", {flush, div_abort, div_start}, 3'b010); end
        step(); #2;
        n_cmp++; if (obs() !== 9'b00100_0000) begin n_err++; $display("FAIL timeout_flush got=%b exp=%b", obs(), 9'b00100_0000); end
        step(); #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL timeout_run got=%b exp=%b", obs(), 9'b0); end
        step();
    endtask

    task automatic test_exc();
        clr(); ID_EX_div = 1'b1; step(); ID_EX_div = 1'b0; step(); step(); step();
        MEM_exc = 1'b1; div_done = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b00101_0000) begin n_err++; $display("FAIL exc_in_div got=%b exp=%b", obs(), 9'b00101_0000); end
        step(); clr(); #2;
        n_cmp++; if (obs() !== 9'b00100_0000) begin n_err++; $display("FAIL exc_flush got=%b exp=%b", obs(), 9'b00100_0000); end
        step(); #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL exc_run got=%b exp=%b", obs(), 9'b0); end
        step(); ID_Rs = 5'd2; ID_use_rs = 1'b1; ID_EX_Rd = 5'd2; ID_EX_RegWrite = 1'b1; ID_EX_Mem2Reg = 1'b1;
        MEM_exc = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b00100_0000) begin n_err++; $display("FAIL exc_beats_stall got=%b exp=%b", obs(), 9'b00100_0000); end
        step(); clr(); MEM_exc = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b00100_0000) begin n_err++; $display("FAIL exc_in_flush got=%b exp=%b", obs(), 9'b00100_0000); end
        step(); MEM_exc = 1'b0; #2;
        n_cmp++; if (obs() !== 9'b00100_0000) begin n_err++; $display("FAIL reflush got=%b exp=%b", obs(), 9'b00100_0000); end
        step(); #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL reflush_run got=%b exp=%b", obs(), 9'b0); end
        step();
    endtask

    task automatic test_reset_mid_div();
        clr(); ID_EX_div = 1'b1; step(); ID_EX_div = 1'b0; step(); step();
        rst = 1'b1; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL rst_in_div got=%b exp=%b", obs(), 9'b0); end
        step(); rst = 1'b0; #2;
        n_cmp++; if (obs() !== 9'b0) begin n_err++; $display("FAIL rst_div_run got=%b exp=%b", obs(), 9'b0); end
        step();
    endtask

    initial begin
        clr();
        test_reset();
        test_load_use();
        test_forward();
        test_div();
        test_timeout();
        test_exc();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
